// File: rtl/conv_tile_scheduler_pkg.sv
// Shared types and helpers for the convolution tile scheduler: FSM state encoding,
// default layer geometry with its last-tile bases, and the per-layer tile count.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  localparam int DEF_N  = 32;
  localparam int DEF_M  = 32;
  localparam int DEF_R  = 64;
  localparam int DEF_C  = 32;
  localparam int DEF_TN = 16;
  localparam int DEF_TM = 16;
  localparam int DEF_TR = 64;
  localparam int DEF_TC = 16;

  // Base value of the final tile along each dimension for the default geometry
  localparam int LAST_N   = DEF_N - DEF_TN;
  localparam int LAST_M   = DEF_M - DEF_TM;
  localparam int LAST_ROW = DEF_R - DEF_TR;
  localparam int LAST_COL = DEF_C - DEF_TC;

  function automatic int tile_count(input int n, input int m, input int r, input int c,
                                    input int tn, input int tm, input int tr, input int tc);
    return (n / tn) * (m / tm) * (r / tr) * (c / tc);
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_tile_index_counter.sv
// One tile-base dimension: steps by STEP on inc and wraps to 0 after reaching LAST.
// wrap is high while the value sits at LAST, so the next dimension can chain on it.
module tile_index_counter #(
  parameter int AW   = 32,
  parameter int STEP = 16,
  parameter int LAST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] value,
  output logic          wrap
);

  logic [AW-1:0] value_q, value_d;

  assign wrap  = (value_q == AW'(LAST));
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = wrap ? '0 : value_q + AW'(STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks a convolution layer tile by tile (m innermost, then n, col, row outermost) and
// drives one tile engine. Optional counters under macro CONV_TILE_SCHED_PERF_EN.
//
// state | meaning
// IDLE  | waiting for layer_start; bases hold the last tile of the previous layer
// ISSUE | one-cycle conv_tile_start with bases already valid
// WAIT  | engine running; bases stable; conv_tile_done advances bases
// NEXT  | new bases visible; pick ISSUE or DONE
// DONE  | one-cycle layer_done
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int AW = 32,
  parameter int N  = 32,
  parameter int M  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          conv_tile_start,
  input  logic          conv_tile_done,
  output logic [AW-1:0] tile_base_n,
  output logic [AW-1:0] tile_base_m,
  output logic [AW-1:0] tile_base_row,
  output logic [AW-1:0] tile_base_col
`ifdef CONV_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [AW-1:0] perf_tiles
`endif
);

  localparam int LAST_N_P   = N - Tn;
  localparam int LAST_M_P   = M - Tm;
  localparam int LAST_ROW_P = R - Tr;
  localparam int LAST_COL_P = C - Tc;

  if ((N % Tn) != 0 || (M % Tm) != 0 || (R % Tr) != 0 || (C % Tc) != 0) begin : g_bad_tiling
    $error("conv_tile_scheduler: layer dimensions must be exact multiples of tile sizes");
  end

  sched_state_e state_q, state_d;
  logic         last_q, last_d;
  logic         start_ok, done_ok, adv, all_last;
  logic         n_wrap, m_wrap, row_wrap, col_wrap;

  assign start_ok = (state_q == IDLE) && layer_start;
  assign done_ok  = (state_q == WAIT) && conv_tile_done;
  assign all_last = m_wrap && n_wrap && col_wrap && row_wrap;
  // Bases move at the end of WAIT so the new tile is visible during NEXT;
  // the final tile is not advanced so its bases persist into IDLE.
  assign adv      = done_ok && !all_last;

  tile_index_counter #(.AW(AW), .STEP(Tm), .LAST(LAST_M_P)) u_cnt_m (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(adv),
    .value(tile_base_m), .wrap(m_wrap));

  tile_index_counter #(.AW(AW), .STEP(Tn), .LAST(LAST_N_P)) u_cnt_n (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(adv && m_wrap),
    .value(tile_base_n), .wrap(n_wrap));

  tile_index_counter #(.AW(AW), .STEP(Tc), .LAST(LAST_COL_P)) u_cnt_col (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(adv && m_wrap && n_wrap),
    .value(tile_base_col), .wrap(col_wrap));

  tile_index_counter #(.AW(AW), .STEP(Tr), .LAST(LAST_ROW_P)) u_cnt_row (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(adv && m_wrap && n_wrap && col_wrap),
    .value(tile_base_row), .wrap(row_wrap));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE:  if (layer_start) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (conv_tile_done) begin
          state_d = NEXT;
          last_d  = all_last;
        end
      end
      NEXT:  state_d = last_q ? DONE : ISSUE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != IDLE);
    conv_tile_start = (state_q == ISSUE);
    layer_done      = (state_q == DONE);
  end

`ifdef CONV_TILE_SCHED_PERF_EN
  logic [31:0]   perf_cycles_q;
  logic [AW-1:0] perf_tiles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
    end else if (start_ok) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
    end else begin
      if (busy && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (done_ok && !(&perf_tiles_q)) perf_tiles_q <= perf_tiles_q + AW'(1);
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_tiles  = perf_tiles_q;
`else
  // Counters are absent in this build.
`endif

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Walks a full convolution layer tile by tile and drives one convolution tile engine. It sits directly upstream of that engine. For each tile it presents stable tile base coordinates (n, m, row, col), issues a one-cycle tile start pulse, and waits for the tile done pulse. It signals layer completion after the last tile. The loop order keeps input-channel accumulation into the same output tile on consecutive tiles.

## Interface
Parameters:
- AW, 32, width of tile base outputs and internal counters
- N, 32, output channels (layer)
- M, 32, input channels (layer)
- R, 64, feature rows (layer)
- C, 32, feature columns (layer)
- Tn, 16, output-channel tile size
- Tm, 16, input-channel tile size
- Tr, 64, row tile size
- Tc, 16, column tile size

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- layer_start  in  1  one-cycle pulse; begins a layer; honoured only in IDLE
- layer_done  out  1  one-cycle pulse after the last tile completes
- busy  out  1  high in every state except IDLE
- conv_tile_start  out  1  one-cycle pulse per tile, to the tile engine
- conv_tile_done  in  1  one-cycle pulse from the tile engine; honoured only in WAIT
- tile_base_n  out  AW  output-channel base of the current tile
- tile_base_m  out  AW  input-channel base of the current tile
- tile_base_row  out  AW  row base of the current tile
- tile_base_col  out  AW  column base of the current tile

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - On layer_start, clear all four bases to 0 and go to ISSUE.
- ISSUE:
  - Assert conv_tile_start for exactly this one cycle, then go to WAIT.
- WAIT:
  - Hold. On conv_tile_done, go to NEXT.
- NEXT:
  - Advance the bases. m is innermost, then n, then col; row is outermost.
  - m += Tm. If the old m == M−Tm, m wraps to 0 and n += Tn.
  - n, col (step Tc) and row (step Tr) wrap and carry the same way.
  - If all four bases were at their last value, go to DONE; otherwise go to ISSUE.
- DONE:
  - Assert layer_done for one cycle, then go to IDLE.
- In DONE and IDLE, the bases hold the last tile's values until the next layer_start.
- Tile count per layer is (N/Tn)·(M/Tm)·(R/Tr)·(C/Tc).
- N, M, R and C must be exact multiples of Tn, Tm, Tr and Tc. A violation is an elaboration-time $error; partial tiles are not supported.
- Ignored events:
  - layer_start while busy.
  - conv_tile_done outside WAIT.
- Tile bases are unsigned AW-bit values. Each comparison is against the constant last value, e.g. M−Tm, so no overflow arises.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-layer aborts immediately, with no layer_done. Asserting rst is the only abort mechanism.
- layer_start in cycle t produces conv_tile_start in cycle t+1, with bases = 0 already valid in t+1.
- conv_tile_done in cycle t produces:
  - new bases in cycle t+1 (NEXT→ISSUE transition registered at the end of t+1);
  - the next conv_tile_start in cycle t+2.
  - This guarantees one cycle of separation after the engine's internal clean cycle (done+1).
- The bases are stable from ISSUE through the whole of WAIT, including the engine's store phase.
- The last tile's conv_tile_done in cycle t produces layer_done in cycle t+2.
- Per-tile overhead is 2 cycles plus engine latency.
- conv_tile_done arriving in the same cycle as ISSUE is ignored; the engine cannot legally produce it that early.

## Configuration
- CONV_TILE_SCHED_PERF_EN defined adds two output ports:
  - perf_cycles (32 bits): counts every cycle from the first ISSUE through DONE inclusive. It is cleared on layer_start.
  - perf_tiles (AW bits): incremented on each accepted conv_tile_done.
  - Both counters saturate at all-ones, hold their value after the layer ends, and reset to 0.
- CONV_TILE_SCHED_PERF_EN undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- A shared package conv_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, NEXT, DONE);
  - localparams for the last-tile values (N−Tn, M−Tm, R−Tr, C−Tc);
  - the tile-count function used by the bench.
- One sub-module is natural: tile_index_counter.
  - It is a single wrap-and-carry counter with STEP and LAST parameters, plus inc, clr, value and wrap ports.
  - Four instances are chained by their wrap outputs.

## Test plan
- Defaults (8 tiles); engine model returns done 20 cycles after each start.
  - Required base sequence (n,m,row,col): (0,0,0,0), (0,16,0,0), (16,0,0,0), (16,16,0,0), (0,0,0,16), (0,16,0,16), (16,0,0,16), (16,16,0,16).
  - Exactly 8 starts, then layer_done 2 cycles after the 8th done.
- Latency check: layer_start at cycle 10 → conv_tile_start at cycle 11; done at cycle 40 → next start at cycle 42.
- Spurious events:
  - layer_start pulsed during WAIT → ignored.
  - conv_tile_done pulsed in IDLE and in ISSUE → no state change.
  - Tile count remains 8.
- Reset mid-layer: rst asserted during the 3rd WAIT → all outputs 0 next cycle and no layer_done. A fresh layer_start then restarts from bases (0,0,0,0).
- Single-tile layer (N=Tn, M=Tm, R=Tr, C=Tc): one start, then layer_done 2 cycles after done. Back-to-back layer_start in the cycle after layer_done is accepted.
- With CONV_TILE_SCHED_PERF_EN and 20-cycle tiles: perf_tiles = 8, and perf_cycles equals the cycle span from the first conv_tile_start through layer_done inclusive.
